cci_mpf_shim_rd_credit: RTL and testbench
=========================================

CCI_MPF_SHIM_RD_CREDIT -- requirements
Module: cci_mpf_shim_rd_credit

Interface
REQ-001 SHALL have parameter MAX_RD_LINES, default 256, meaning the maximum read lines in flight toward the FIU.
REQ-002 SHALL have parameter ALMFULL_SLACK, default 8, meaning the requests the AFU may still issue after almost-full asserts.
REQ-003 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-004 SHALL have port reset  input  1  meaning the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port fiu  cci_mpf_if.to_fiu  interface  meaning the connection toward the platform.
REQ-006 SHALL have port afu  cci_mpf_if.to_afu  interface  meaning the connection toward user logic.
REQ-007 SHALL have port rd_lines_out  output  $clog2(MAX_RD_LINES+4*ALMFULL_SLACK+1)  meaning the current in-flight read-line count.
REQ-008 SHALL have port err_underflow  output  1  meaning a sticky flag set when a read response arrives with a zero count.

Function
REQ-009 SHALL register afu.c0Tx into fiu.c0Tx with exactly 1-cycle latency, header and valid together.
REQ-010 SHALL pass c1Tx, c2Tx, c0Rx and c1Rx combinationally, and pass fiu.c1TxAlmFull to afu.c1TxAlmFull.
REQ-011 SHALL drive afu.reset from reset delayed by one register stage.
REQ-012 SHALL compute request lines from the c0Tx cl_len field: eCL_LEN_1 gives 1, eCL_LEN_2 gives 2, eCL_LEN_4 gives 4.
REQ-013 SHALL add those lines to the count in the cycle the registered read request is valid on fiu.c0Tx.
REQ-014 SHALL subtract 1 from the count for each fiu.c0Rx read-response beat (rspValid with resp_type eRSP_RDLINE); MMIO and other responses SHALL be ignored.
REQ-015 SHALL apply a simultaneous increment and decrement in the same cycle as one net update (count + lines - 1).
REQ-016 SHALL drive afu.c0TxAlmFull registered, equal to fiu.c0TxAlmFull OR (count + 4*ALMFULL_SLACK >= MAX_RD_LINES).
REQ-017 SHALL size the counter so that count never wraps for a compliant AFU: maximum MAX_RD_LINES + 4*ALMFULL_SLACK.
REQ-018 SHALL, on a response beat arriving while count == 0, hold count at 0 and set err_underflow.
REQ-019 SHALL keep err_underflow set until reset.
REQ-020 SHALL pass every request unmodified: the block throttles only through almost-full and never drops or stalls a request.
REQ-021 SHALL treat c0Tx write-type or invalid-valid cycles as zero lines (no count change).

Reset
REQ-022 SHALL, while reset is high, clear fiu.c0Tx valid, count, rd_lines_out and err_underflow.
REQ-023 SHALL force afu.c0TxAlmFull to 1 during reset and for the first cycle after reset.
REQ-024 SHALL, on reset asserted mid-operation, discard outstanding count state and drop any request held in the c0Tx register.
REQ-025 SHALL ignore responses arriving during reset.

Structure
REQ-026 SHALL place a cl_len-to-line-count function in cci_mpf_if_pkg for reuse by other shims.
REQ-027 SHALL define no new typedefs; the block SHALL use the t_if_cci_mpf_c0_Tx and t_if_cci_c0_Rx types.
REQ-028 SHALL implement the up/down counter with saturating underflow as sub-module cci_mpf_shim_rd_credit_cnt (inputs: inc amount, dec, outputs: count, underflow pulse).
REQ-029 SHALL make the top level contain only the c0Tx register, the almost-full compare, the reset pipeline and the pass-through wiring.

Verification
REQ-030 SHALL cover: single eCL_LEN_4 read -> fiu valid 1 cycle later, rd_lines_out = 4 next cycle; 4 response beats -> count 0.
REQ-031 SHALL cover, with MAX=256 and SLACK=8: issue 56 eCL_LEN_4 reads, no responses -> count 224, afu.c0TxAlmFull = 1; one response -> 223, almFull = 0.
REQ-032 SHALL cover: same-cycle eCL_LEN_2 request plus one response with count 10 -> count 11.
REQ-033 SHALL cover: response with count 0 -> count stays 0, err_underflow = 1 and remains 1 until reset.
REQ-034 SHALL cover: reset asserted with count 37 and a request pending in the register -> next cycle count 0, fiu.c0Tx valid 0, afu.c0TxAlmFull 1 for reset plus 1 cycle.
REQ-035 SHALL cover: fiu.c0TxAlmFull = 1 with count 0 -> afu.c0TxAlmFull = 1 one cycle later; a write on c1Tx appears on fiu.c1Tx in the same cycle.

Source files
------------

// File: rtl/cci_mpf_if_pkg.sv
// CCI-P / MPF channel types shared by the MPF shims, plus small decode helpers.
// Pure declarations; no logic and no flow control of its own.
package cci_mpf_if_pkg;

  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int CCI_ADDR_WIDTH   = 42;
  localparam int CCI_MDATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_cci_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRFENCE  = 4'h2,
    eREQ_RDLINE_I = 4'h4,
    eREQ_RDLINE_S = 4'h5
  } t_cci_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE  = 4'h0,
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h2,
    eRSP_UMSG    = 4'h4
  } t_cci_rsp;

  typedef struct packed {
    t_cci_clLen                 cl_len;
    t_cci_req                   req_type;
    logic [CCI_ADDR_WIDTH-1:0]  address;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_cci_mpf_c0_ReqMemHdr;

  typedef struct packed {
    t_cci_mpf_c0_ReqMemHdr hdr;
    logic                  valid;
  } t_if_cci_mpf_c0_Tx;

  typedef struct packed {
    t_cci_clLen                 cl_len;
    t_cci_req                   req_type;
    logic [CCI_ADDR_WIDTH-1:0]  address;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_cci_mpf_c1_ReqMemHdr;

  typedef struct packed {
    t_cci_mpf_c1_ReqMemHdr       hdr;
    logic [CCI_CLDATA_WIDTH-1:0] data;
    logic                        valid;
  } t_if_cci_mpf_c1_Tx;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
    logic        mmioRdValid;
  } t_if_cci_c2_Tx;

  typedef struct packed {
    t_cci_rsp                   resp_type;
    logic [1:0]                 cl_num;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_cci_c0_RspMemHdr;

  typedef struct packed {
    t_cci_c0_RspMemHdr           hdr;
    logic [CCI_CLDATA_WIDTH-1:0] data;
    logic                        rspValid;
    logic                        mmioRdValid;
    logic                        mmioWrValid;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    t_cci_rsp                   resp_type;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_cci_c1_RspMemHdr;

  typedef struct packed {
    t_cci_c1_RspMemHdr hdr;
    logic              rspValid;
  } t_if_cci_c1_Rx;

  // Reserved cl_len encoding counts as zero lines so it can never inflate credit.
  function automatic logic [2:0] cciLinesFromClLen(input t_cci_clLen cl_len);
    case (cl_len)
      eCL_LEN_1: return 3'd1;
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// MPF channel bundle between a shim and its neighbours (platform side / user side).
// Wiring only; throttling is expressed through the almost-full signals.
interface cci_mpf_if;
  import cci_mpf_if_pkg::*;

  logic              reset;
  t_if_cci_mpf_c0_Tx c0Tx;
  t_if_cci_mpf_c1_Tx c1Tx;
  t_if_cci_c2_Tx     c2Tx;
  logic              c0TxAlmFull;
  logic              c1TxAlmFull;
  t_if_cci_c0_Rx     c0Rx;
  t_if_cci_c1_Rx     c1Rx;

  modport to_fiu (
    output c0Tx, c1Tx, c2Tx,
    input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport to_afu (
    output reset,
    input  c0Tx, c1Tx, c2Tx,
    output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );
endinterface

// File: rtl/cci_mpf_shim_rd_credit_cnt.sv
// In-flight read-line up/down counter; inc and dec net into one update, registered (1 cycle).
// A dec at zero is dropped (count saturates) and reported as a one-cycle underflow pulse.
module cci_mpf_shim_rd_credit_cnt #(
  parameter int CNT_W = 9,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    underflow = dec && (count_q == '0) && !reset;
    count_d   = count_q + CNT_W'(inc);
    if (dec && (count_q != '0)) begin
      count_d = count_d - CNT_W'(1);
    end
    if (reset) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cci_mpf_shim_rd_credit.sv
// Read-credit shim: registers c0Tx (1 cycle), counts read lines in flight, raises c0 almost-full.
// Never stalls or drops requests; throttling is only via afu.c0TxAlmFull (registered, 1 cycle).
module cci_mpf_shim_rd_credit
  import cci_mpf_if_pkg::*;
#(
  parameter int MAX_RD_LINES  = 256,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic             clk,
  input  logic             reset,
  cci_mpf_if.to_fiu        fiu,
  cci_mpf_if.to_afu        afu,
  output logic [$clog2(MAX_RD_LINES+4*ALMFULL_SLACK+1)-1:0] rd_lines_out,
  output logic             err_underflow
);

  localparam int CNT_W = $clog2(MAX_RD_LINES + 4*ALMFULL_SLACK + 1);

  t_if_cci_mpf_c0_Tx c0_tx_d, c0_tx_q;
  logic              reset_d, reset_q;
  logic              alm_full_d, alm_full_q;
  logic              err_underflow_d, err_underflow_q;
  logic [2:0]        rd_inc;
  logic              rd_dec;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_underflow;

  always_comb begin
    c0_tx_d = afu.c0Tx;
    if (reset) begin
      c0_tx_d.valid = 1'b0;
    end
    reset_d = reset;

    // Lines are charged when the request actually leaves on fiu.c0Tx.
    rd_inc = '0;
    if (c0_tx_q.valid &&
        ((c0_tx_q.hdr.req_type == eREQ_RDLINE_I) || (c0_tx_q.hdr.req_type == eREQ_RDLINE_S))) begin
      rd_inc = cciLinesFromClLen(c0_tx_q.hdr.cl_len);
    end
    rd_dec = fiu.c0Rx.rspValid && (fiu.c0Rx.hdr.resp_type == eRSP_RDLINE);

    alm_full_d = reset || reset_q || fiu.c0TxAlmFull ||
                 ((32'(rd_cnt) + 32'(4*ALMFULL_SLACK)) >= 32'(MAX_RD_LINES));

    err_underflow_d = err_underflow_q || rd_underflow;
    if (reset) begin
      err_underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    c0_tx_q         <= c0_tx_d;
    reset_q         <= reset_d;
    alm_full_q      <= alm_full_d;
    err_underflow_q <= err_underflow_d;
  end

  cci_mpf_shim_rd_credit_cnt #(
    .CNT_W (CNT_W),
    .INC_W (3)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (rd_inc),
    .dec       (rd_dec),
    .count     (rd_cnt),
    .underflow (rd_underflow)
  );

  assign fiu.c0Tx        = c0_tx_q;
  assign fiu.c1Tx        = afu.c1Tx;
  assign fiu.c2Tx        = afu.c2Tx;
  assign afu.c0Rx        = fiu.c0Rx;
  assign afu.c1Rx        = fiu.c1Rx;
  assign afu.c1TxAlmFull = fiu.c1TxAlmFull;
  assign afu.c0TxAlmFull = alm_full_q;
  assign afu.reset       = reset_q;

  assign rd_lines_out  = rd_cnt;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_cci_mpf_shim_rd_credit.sv
// Directed bench for the read-credit shim: inputs driven and outputs sampled 1ns after posedge.
module tb_cci_mpf_shim_rd_credit;
  import cci_mpf_if_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] rd_lines_out;
  logic       err_underflow;
  int         n_vec = 0;
  int         n_err = 0;

  cci_mpf_if fiu_if();
  cci_mpf_if afu_if();

  cci_mpf_shim_rd_credit #(
    .MAX_RD_LINES  (256),
    .ALMFULL_SLACK (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fiu           (fiu_if),
    .afu           (afu_if),
    .rd_lines_out  (rd_lines_out),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    afu_if.c0Tx        = '0;
    afu_if.c1Tx        = '0;
    afu_if.c2Tx        = '0;
    fiu_if.c0Rx        = '0;
    fiu_if.c1Rx        = '0;
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  function automatic t_if_cci_mpf_c0_Tx rd_req(input t_cci_clLen len, input logic [15:0] md);
    t_if_cci_mpf_c0_Tx r;
    r = '0;
    r.valid        = 1'b1;
    r.hdr.cl_len   = len;
    r.hdr.req_type = eREQ_RDLINE_I;
    r.hdr.address  = 42'h1000 + 42'(md);
    r.hdr.mdata    = md;
    return r;
  endfunction

  function automatic t_if_cci_c0_Rx rd_rsp(input t_cci_rsp kind);
    t_if_cci_c0_Rx r;
    r = '0;
    r.rspValid      = 1'b1;
    r.hdr.resp_type = kind;
    r.hdr.mdata     = 16'h00a5;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick(); tick(); tick();
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b0) begin n_err++; $display("FAIL rst_c0tx_vld: got %b want 0", fiu_if.c0Tx.valid); end
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", rd_lines_out); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_underflow); end
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL rst_almfull: got %b want 1", afu_if.c0TxAlmFull); end
    n_vec++; if (afu_if.reset !== 1'b1) begin n_err++; $display("FAIL rst_afu_reset: got %b want 1", afu_if.reset); end
    reset = 1'b0;
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL rst_almfull_plus1: got %b want 1", afu_if.c0TxAlmFull); end
    n_vec++; if (afu_if.reset !== 1'b0) begin n_err++; $display("FAIL rst_afu_reset_rel: got %b want 0", afu_if.reset); end
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL rst_almfull_rel: got %b want 0", afu_if.c0TxAlmFull); end
  endtask

  task automatic test_single_read();
    t_if_cci_c0_Rx rsp;
    afu_if.c0Tx = rd_req(eCL_LEN_4, 16'h0123);
    #1;
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b0) begin n_err++; $display("FAIL single_not_comb: got %b want 0", fiu_if.c0Tx.valid); end
    tick();
    afu_if.c0Tx = '0;
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b1) begin n_err++; $display("FAIL single_fiu_vld: got %b want 1", fiu_if.c0Tx.valid); end
    n_vec++; if (fiu_if.c0Tx.hdr.mdata !== 16'h0123) begin n_err++; $display("FAIL single_fiu_mdata: got %h want 0123", fiu_if.c0Tx.hdr.mdata); end
    n_vec++; if (fiu_if.c0Tx.hdr.cl_len !== eCL_LEN_4) begin n_err++; $display("FAIL single_fiu_len: got %b want 11", fiu_if.c0Tx.hdr.cl_len); end
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL single_cnt_early: got %0d want 0", rd_lines_out); end
    tick();
    n_vec++; if (rd_lines_out !== 9'd4) begin n_err++; $display("FAIL single_cnt4: got %0d want 4", rd_lines_out); end
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b0) begin n_err++; $display("FAIL single_fiu_vld_off: got %b want 0", fiu_if.c0Tx.valid); end
    rsp = rd_rsp(eRSP_RDLINE);
    for (int i = 0; i < 4; i++) begin
      fiu_if.c0Rx = rsp;
      #1;
      n_vec++; if (afu_if.c0Rx !== rsp) begin n_err++; $display("FAIL single_c0rx_pass: got %h want %h", afu_if.c0Rx.hdr, rsp.hdr); end
      tick();
      n_vec++; if (rd_lines_out !== 9'(3 - i)) begin n_err++; $display("FAIL single_drain: got %0d want %0d", rd_lines_out, 3 - i); end
    end
    drive_idle();
  endtask

  task automatic test_ignored_traffic();
    t_if_cci_mpf_c0_Tx wr;
    t_if_cci_c0_Rx     mm;
    fiu_if.c0Rx = rd_rsp(eRSP_UMSG);
    tick();
    mm = '0;
    mm.mmioRdValid = 1'b1;
    fiu_if.c0Rx = mm;
    tick();
    fiu_if.c0Rx = '0;
    tick();
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL ign_rsp_cnt: got %0d want 0", rd_lines_out); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL ign_rsp_err: got %b want 0", err_underflow); end
    wr = rd_req(eCL_LEN_4, 16'h0777);
    wr.hdr.req_type = eREQ_WRLINE_I;
    afu_if.c0Tx = wr;
    tick();
    afu_if.c0Tx = '0;
    n_vec++; if (fiu_if.c0Tx !== wr) begin n_err++; $display("FAIL ign_wr_pass: got %h want %h", fiu_if.c0Tx, wr); end
    tick();
    tick();
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL ign_wr_cnt: got %0d want 0", rd_lines_out); end
  endtask

  task automatic test_almfull();
    do_reset();
    for (int i = 0; i < 56; i++) begin
      afu_if.c0Tx = rd_req(eCL_LEN_4, 16'(i));
      tick();
    end
    afu_if.c0Tx = '0;
    tick();
    n_vec++; if (rd_lines_out !== 9'd224) begin n_err++; $display("FAIL alm_cnt224: got %0d want 224", rd_lines_out); end
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL alm_at220: got %b want 0", afu_if.c0TxAlmFull); end
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL alm_at224: got %b want 1", afu_if.c0TxAlmFull); end
    fiu_if.c0Rx = rd_rsp(eRSP_RDLINE);
    tick();
    fiu_if.c0Rx = '0;
    n_vec++; if (rd_lines_out !== 9'd223) begin n_err++; $display("FAIL alm_cnt223: got %0d want 223", rd_lines_out); end
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL alm_lag: got %b want 1", afu_if.c0TxAlmFull); end
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL alm_at223: got %b want 0", afu_if.c0TxAlmFull); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    afu_if.c0Tx = rd_req(eCL_LEN_4, 16'h0010); tick();
    afu_if.c0Tx = rd_req(eCL_LEN_4, 16'h0011); tick();
    afu_if.c0Tx = rd_req(eCL_LEN_2, 16'h0012); tick();
    afu_if.c0Tx = '0;
    tick();
    n_vec++; if (rd_lines_out !== 9'd10) begin n_err++; $display("FAIL same_cnt10: got %0d want 10", rd_lines_out); end
    afu_if.c0Tx = rd_req(eCL_LEN_2, 16'h0013);
    tick();
    afu_if.c0Tx = '0;
    fiu_if.c0Rx = rd_rsp(eRSP_RDLINE);
    tick();
    fiu_if.c0Rx = '0;
    n_vec++; if (rd_lines_out !== 9'd11) begin n_err++; $display("FAIL same_cnt11: got %0d want 11", rd_lines_out); end
    tick();
    n_vec++; if (rd_lines_out !== 9'd11) begin n_err++; $display("FAIL same_cnt11_hold: got %0d want 11", rd_lines_out); end
  endtask

  task automatic test_underflow();
    do_reset();
    fiu_if.c0Rx = rd_rsp(eRSP_RDLINE);
    tick();
    fiu_if.c0Rx = '0;
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL uf_cnt0: got %0d want 0", rd_lines_out); end
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_err_set: got %b want 1", err_underflow); end
    afu_if.c0Tx = rd_req(eCL_LEN_1, 16'h0020);
    tick();
    afu_if.c0Tx = '0;
    tick();
    n_vec++; if (rd_lines_out !== 9'd1) begin n_err++; $display("FAIL uf_cnt1: got %0d want 1", rd_lines_out); end
    tick(); tick(); tick();
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_err_sticky: got %b want 1", err_underflow); end
    reset = 1'b1;
    tick();
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL uf_err_clr: got %b want 0", err_underflow); end
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      afu_if.c0Tx = rd_req(eCL_LEN_4, 16'(16'h0100 + i));
      tick();
    end
    afu_if.c0Tx = rd_req(eCL_LEN_1, 16'h0200);
    tick();
    afu_if.c0Tx = '0;
    tick();
    n_vec++; if (rd_lines_out !== 9'd37) begin n_err++; $display("FAIL mid_cnt37: got %0d want 37", rd_lines_out); end
    afu_if.c0Tx = rd_req(eCL_LEN_4, 16'h0300);
    tick();
    afu_if.c0Tx = '0;
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", fiu_if.c0Tx.valid); end
    reset = 1'b1;
    fiu_if.c0Rx = rd_rsp(eRSP_RDLINE);
    tick();
    fiu_if.c0Rx = '0;
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL mid_cnt0: got %0d want 0", rd_lines_out); end
    n_vec++; if (fiu_if.c0Tx.valid !== 1'b0) begin n_err++; $display("FAIL mid_drop: got %b want 0", fiu_if.c0Tx.valid); end
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL mid_alm_rst: got %b want 1", afu_if.c0TxAlmFull); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", err_underflow); end
    reset = 1'b0;
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL mid_alm_plus1: got %b want 1", afu_if.c0TxAlmFull); end
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL mid_cnt_after: got %0d want 0", rd_lines_out); end
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL mid_alm_rel: got %b want 0", afu_if.c0TxAlmFull); end
  endtask

  task automatic test_fiu_almfull_passthru();
    t_if_cci_mpf_c1_Tx w;
    t_if_cci_c2_Tx     m;
    t_if_cci_c1_Rx     r1;
    fiu_if.c0TxAlmFull = 1'b1;
    fiu_if.c1TxAlmFull = 1'b1;
    #1;
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL pt_alm_reg: got %b want 0", afu_if.c0TxAlmFull); end
    n_vec++; if (afu_if.c1TxAlmFull !== 1'b1) begin n_err++; $display("FAIL pt_c1alm: got %b want 1", afu_if.c1TxAlmFull); end
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL pt_alm_fiu: got %b want 1", afu_if.c0TxAlmFull); end
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    tick();
    n_vec++; if (afu_if.c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL pt_alm_clr: got %b want 0", afu_if.c0TxAlmFull); end
    w = '0;
    w.valid        = 1'b1;
    w.hdr.req_type = eREQ_WRLINE_M;
    w.hdr.cl_len   = eCL_LEN_2;
    w.hdr.address  = 42'h3_0000_beef;
    w.hdr.mdata    = 16'h5a5a;
    w.data         = {16{32'hdead_0000}} ^ 512'h1234_5678;
    m = '0;
    m.tid = 9'h1a5;
    m.data = 64'h0123_4567_89ab_cdef;
    m.mmioRdValid = 1'b1;
    r1 = '0;
    r1.rspValid = 1'b1;
    r1.hdr.resp_type = eRSP_WRLINE;
    r1.hdr.mdata = 16'h0c1c;
    afu_if.c1Tx = w;
    afu_if.c2Tx = m;
    fiu_if.c1Rx = r1;
    #1;
    n_vec++; if (fiu_if.c1Tx.hdr !== w.hdr || fiu_if.c1Tx.valid !== 1'b1) begin n_err++; $display("FAIL pt_c1tx_hdr: got %h want %h", fiu_if.c1Tx.hdr, w.hdr); end
    n_vec++; if (fiu_if.c1Tx.data !== w.data) begin n_err++; $display("FAIL pt_c1tx_data: got %h want %h", fiu_if.c1Tx.data[63:0], w.data[63:0]); end
    n_vec++; if (fiu_if.c2Tx !== m) begin n_err++; $display("FAIL pt_c2tx: got %h want %h", fiu_if.c2Tx, m); end
    n_vec++; if (afu_if.c1Rx !== r1) begin n_err++; $display("FAIL pt_c1rx: got %h want %h", afu_if.c1Rx, r1); end
    tick();
    drive_idle();
    n_vec++; if (rd_lines_out !== 9'd0) begin n_err++; $display("FAIL pt_cnt: got %0d want 0", rd_lines_out); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_ignored_traffic();
    test_almfull();
    test_same_cycle();
    test_underflow();
    test_reset_midop();
    test_fiu_almfull_passthru();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
